// File: rtl/wam_gen.sv
// Whack-a-mole game core: a 16-hole mole field with per-hole lifetimes, spawned
// from an LFSR draw on game ticks and cleared by touch hits or by expiry.
module wam_gen (
  input  logic        clk_19,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  input  logic [3:0]  age,
  input  logic [7:0]  rto,
  input  logic [15:0] hit_btn,
  output logic [15:0] mole,
  output logic        hit,
  output logic        whiff,
  output logic        miss,
  output logic        running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  life_q [16];
  logic [3:0]  life_d [16];
  logic [15:0] mole_q, mole_d;
  logic        hit_q, hit_d;
  logic        whiff_q, whiff_d;
  logic        miss_q, miss_d;
  logic        running_q, running_d;

  logic [15:0] hitmask;
  logic [15:0] expired;
  logic [3:0]  cand;

  // A zero age still gives the mole one tick of visibility.
  function automatic logic [3:0] load_life(input logic [3:0] a);
    return (a == 4'd0) ? 4'd1 : a;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_next(lfsr_q);
    hit_d     = 1'b0;
    whiff_d   = 1'b0;
    miss_d    = 1'b0;
    hitmask   = 16'h0000;
    expired   = 16'h0000;
    cand      = lfsr_q[3:0];
    for (int i = 0; i < 16; i++) life_d[i] = life_q[i];

    if (state_q == IDLE) begin
      for (int i = 0; i < 16; i++) life_d[i] = 4'd0;
      if (start && !stop) state_d = RUN;
    end else if (stop || start) begin
      // stop leaves the round, start restarts it; either way the field empties silently
      for (int i = 0; i < 16; i++) life_d[i] = 4'd0;
      if (stop) state_d = IDLE;
    end else begin
      hitmask = hit_btn & mole_q;
      hit_d   = |hitmask;
      whiff_d = |(hit_btn & ~mole_q);
      for (int i = 0; i < 16; i++)
        if (hitmask[i]) life_d[i] = 4'd0;
      if (tick) begin
        for (int i = 0; i < 16; i++) begin
          if (life_d[i] != 4'd0) begin
            if (life_d[i] == 4'd1) expired[i] = 1'b1;
            life_d[i] = life_d[i] - 4'd1;
          end
        end
        miss_d = |expired;
        if ((lfsr_q[15:8] < rto) && (life_d[cand] == 4'd0) &&
            !hitmask[cand] && !expired[cand])
          life_d[cand] = load_life(age);
      end
    end

    for (int i = 0; i < 16; i++) mole_d[i] = (life_d[i] != 4'd0);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk_19) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= 16'hACE1;
      mole_q    <= 16'h0000;
      hit_q     <= 1'b0;
      whiff_q   <= 1'b0;
      miss_q    <= 1'b0;
      running_q <= 1'b0;
      for (int i = 0; i < 16; i++) life_q[i] <= 4'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      mole_q    <= mole_d;
      hit_q     <= hit_d;
      whiff_q   <= whiff_d;
      miss_q    <= miss_d;
      running_q <= running_d;
      for (int i = 0; i < 16; i++) life_q[i] <= life_d[i];
    end
  end

  assign mole    = mole_q;
  assign hit     = hit_q;
  assign whiff   = whiff_q;
  assign miss    = miss_q;
  assign running = running_q;

endmodule

// File: tb/tb_wam_gen.sv
// Directed bench for wam_gen: a reference LFSR predicts spawn holes and draws,
// and each scenario checks moles and pulses against hand-derived values.
module tb_wam_gen;

  logic        clk_19 = 1'b0;
  logic        rst_n;
  logic        start, stop, tick;
  logic [3:0]  age;
  logic [7:0]  rto;
  logic [15:0] hit_btn;
  logic [15:0] mole;
  logic        hit, whiff, miss, running;

  int vec  = 0;
  int errs = 0;
  logic [15:0] lf;
  logic [15:0] exp_m;
  logic [15:0] acc;

  wam_gen dut (
    .clk_19  (clk_19),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .tick    (tick),
    .age     (age),
    .rto     (rto),
    .hit_btn (hit_btn),
    .mole    (mole),
    .hit     (hit),
    .whiff   (whiff),
    .miss    (miss),
    .running (running)
  );

  always #5 clk_19 = ~clk_19;

  // Reference LFSR: value visible after an edge is the one the DUT draws from next edge.
  always @(posedge clk_19) begin
    if (!rst_n) lf <= 16'hACE1;
    else        lf <= {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_19);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Idle (no tick) until the next draw is spawnable and, if hole>=0, lands on that hole.
  task automatic seek(input int hole);
    int n;
    n = 0;
    while ((lf[15:8] == 8'hFF || (hole >= 0 && lf[3:0] != hole[3:0])) && n < 400) begin
      cyc();
      n++;
    end
    chk("seek_bound", {15'd0, n < 400}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    age = 4'd0; rto = 8'd0; hit_btn = 16'h0000;
    repeat (3) cyc();
    chk("rst_mole", mole, 16'h0000);
    chk("rst_flags", {12'd0, hit, whiff, miss, running}, 16'h0000);
    rst_n = 1'b1;

    // Start, single spawn at the candidate hole, expiry after age ticks
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_running", {15'd0, running}, 16'd1);
    age = 4'd3; rto = 8'd255;
    seek(-1);
    exp_m = 16'd1 << lf[3:0];
    pulse_tick(); rto = 8'd0;
    chk("spawn_one", mole, exp_m);
    pulse_tick();
    chk("life_2", mole, exp_m);
    pulse_tick();
    chk("life_1", mole, exp_m);
    chk("no_miss_yet", {15'd0, miss}, 16'd0);
    pulse_tick();
    chk("expired", mole, 16'h0000);
    chk("miss_pulse", {15'd0, miss}, 16'd1);
    cyc();
    chk("miss_one_cycle", {15'd0, miss}, 16'd0);

    // rto=0 never spawns
    acc = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      pulse_tick();
      acc = acc | mole | {12'd0, hit, whiff, miss, 1'b0};
    end
    chk("rto0_quiet", acc, 16'h0000);

    // Hit on the same tick the mole in hole 5 would expire
    age = 4'd2; rto = 8'd255;
    seek(5);
    pulse_tick(); rto = 8'd0;
    chk("h5_spawn", mole, 16'h0020);
    pulse_tick();
    chk("h5_life1", mole, 16'h0020);
    hit_btn = 16'h0020; tick = 1'b1;
    cyc();
    hit_btn = 16'h0000; tick = 1'b0;
    chk("h5_cleared", mole, 16'h0000);
    chk("h5_hit_miss_whiff", {13'd0, hit, miss, whiff}, 16'h0004);

    // Whiff in RUN, then nothing in IDLE
    hit_btn = 16'h0001; cyc(); hit_btn = 16'h0000;
    chk("whiff_hit", {14'd0, whiff, hit}, 16'h0002);
    cyc();
    chk("whiff_one_cycle", {15'd0, whiff}, 16'd0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_idle", {15'd0, running}, 16'd0);
    hit_btn = 16'h0001; tick = 1'b1; rto = 8'd255; age = 4'd4;
    cyc();
    hit_btn = 16'h0000; tick = 1'b0;
    chk("idle_quiet", {mole[15:4], mole[3:0] | {1'b0, hit, whiff, miss}}, 16'h0000);

    // Restart in RUN, then start+stop together while moles live
    age = 4'd15;
    start = 1'b1; cyc(); start = 1'b0;
    seek(-1);
    exp_m = 16'd1 << lf[3:0];
    pulse_tick();
    chk("restart_pre", mole, exp_m);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_clear", mole, 16'h0000);
    chk("restart_running", {15'd0, running}, 16'd1);
    seek(-1);
    pulse_tick();
    pulse_tick();
    chk("live_before_stop", {15'd0, mole != 16'h0000}, 16'd1);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("ss_mole", mole, 16'h0000);
    chk("ss_run_miss", {14'd0, running, miss}, 16'd0);

    // age=0 lives exactly one tick
    start = 1'b1; cyc(); start = 1'b0;
    age = 4'd0; rto = 8'd255;
    seek(-1);
    exp_m = 16'd1 << lf[3:0];
    pulse_tick(); rto = 8'd0;
    chk("age0_spawn", mole, exp_m);
    pulse_tick();
    chk("age0_gone", mole, 16'h0000);
    chk("age0_miss", {15'd0, miss}, 16'd1);

    // Mid-round reset
    age = 4'd6; rto = 8'd255;
    seek(-1);
    pulse_tick(); rto = 8'd0;
    chk("mid_live", {15'd0, mole != 16'h0000}, 16'd1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("mid_rst_mole", mole, 16'h0000);
    chk("mid_rst_flags", {14'd0, running, miss}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
